memory_interface: RTL and testbench
===================================

MEMORY_INTERFACE -- requirements
Module: memory_interface

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum number of cycles to wait for mem_ack before the access is aborted.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 addr_in  input  32  byte address from the address register memory-address output.
REQ-005 start  input  1  pulse that requests one access; sampled in IDLE only.
REQ-006 wr  input  1  1 = write, 0 = read; sampled with start.
REQ-007 size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 wdata  input  32  write data, LSB-aligned; sampled with start.
REQ-009 mem_addr  output  32  word-aligned bus address, {addr[31:2],2'b00}.
REQ-010 mem_wdata  output  32  write data replicated into the selected byte lanes.
REQ-011 mem_be  output  4  byte-lane enables.
REQ-012 mem_req  output  1  bus request.
REQ-013 mem_we  output  1  bus write strobe.
REQ-014 mem_ack  input  1  bus completion strobe.
REQ-015 mem_rdata  input  32  bus read data, valid in the mem_ack cycle.
REQ-016 rdata  output  32  extracted, zero-extended read result.
REQ-017 busy  output  1  high while an access is in flight.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 fault  output  1  error flag, valid with done.
REQ-020 inc_address  output  32  latched address + 4, fed to the incrementer bus.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and DONE; busy SHALL be 1 exactly in ACCESS.
REQ-022 IDLE, start=1, aligned, size!=11: latch addr/wr/size/wdata, set inc_address=addr_in+4 (mod 2^32), go to ACCESS next cycle.
REQ-023 Alignment: halfword SHALL require addr[0]=0; word SHALL require addr[1:0]=00; byte has no requirement.
REQ-024 IDLE, start=1 with a misaligned address or size=11: go to DONE, assert fault, drive no bus cycle, still update inc_address.
REQ-025 In ACCESS, mem_req SHALL be 1 and mem_we SHALL equal the latched wr; mem_addr, mem_be and mem_wdata SHALL be held stable.
REQ-026 mem_be SHALL be: byte 0001<<addr[1:0]; halfword 0011<<addr[1:0]; word 1111.
REQ-027 mem_wdata SHALL be the byte replicated 4x for byte accesses, the halfword replicated 2x for halfword accesses, and wdata for word accesses.
REQ-028 ACCESS with mem_ack=1: for reads, capture rdata = selected lane(s) of mem_rdata shifted to bit 0 and zero-extended; go to DONE with fault=0.
REQ-029 Latency: an acked access SHALL assert done exactly one cycle after the mem_ack cycle; minimum start-to-done is 2 cycles.
REQ-030 A timeout counter SHALL clear on entry to ACCESS and increment each non-ack cycle; when it reaches TIMEOUT without mem_ack, go to DONE with fault=1 and leave rdata unchanged.
REQ-031 A mem_ack arriving in the same cycle the count reaches TIMEOUT SHALL count as success.
REQ-032 DONE SHALL last one cycle with done=1 and then return to IDLE; fault SHALL hold its value until the next accepted start.
REQ-033 start in ACCESS or DONE SHALL be ignored, with no queuing.
REQ-034 mem_ack in IDLE or DONE SHALL be ignored.
REQ-035 Outside ACCESS, mem_req, mem_we and mem_be SHALL be 0.

Reset
REQ-036 When rst_n=0, the block SHALL immediately go to IDLE with mem_req=0, mem_we=0, mem_be=0, busy=0, done=0, fault=0, rdata=0, inc_address=0 and mem_addr=0, mem_wdata=0; counter=0.
REQ-037 Reset mid-ACCESS SHALL drop mem_req asynchronously; no done pulse SHALL follow.

Verification
REQ-038 Word read: addr=0x100, ack after 2 cycles with rdata 0xDEADBEEF -> mem_be=1111, rdata=0xDEADBEEF, done pulse, fault=0, inc_address=0x104.
REQ-039 Byte write: addr=0x203, wdata=0x5A -> mem_addr=0x200, mem_be=1000, mem_wdata=0x5A5A5A5A, mem_we=1.
REQ-040 Halfword read: addr=0x12, mem_rdata=0xAABBCCDD -> mem_be=1100, rdata=0x0000AABB.
REQ-041 Misaligned word: addr=0x102 -> no mem_req, done=1 with fault=1 one cycle after start.
REQ-042 Timeout: mem_ack never asserted -> done with fault=1 after TIMEOUT ACCESS cycles; start during busy is ignored.
REQ-043 Wrap and reset: addr=0xFFFFFFFC -> inc_address=0x00000000; rst_n low mid-ACCESS -> mem_req=0 immediately and no done pulse.

Source files
------------

// File: rtl/memory_interface_if.sv
// Memory-side bus bundle: word-aligned request with byte-lane enables,
// single-cycle ack strobe carrying read data.
interface memory_interface_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_be, mem_req, mem_we,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_be, mem_req, mem_we,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/memory_interface.sv
// Single-access load/store unit: aligns byte/halfword/word accesses onto a
// 32-bit bus, extracts read lanes, and aborts with a fault on timeout.
module memory_interface #(
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          addr_in,
  input  logic                 start,
  input  logic                 wr,
  input  logic [1:0]           size,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [31:0]          inc_address,
  memory_interface_if.master   bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      addr_q;
  logic             wr_q;
  logic [1:0]       size_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt;
  logic             misaligned;
  logic             last_wait;

  function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] ofs);
    case (sz)
      2'b00:   lane_enables = 4'b0001 << ofs;
      2'b01:   lane_enables = 4'b0011 << ofs;
      2'b10:   lane_enables = 4'b1111;
      default: lane_enables = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   replicate = {4{d[7:0]}};
      2'b01:   replicate = {2{d[15:0]}};
      default: replicate = d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] sz, input logic [1:0] ofs,
                                          input logic [31:0] d);
    logic [31:0] shifted;
    shifted = d >> {ofs, 3'b000};
    case (sz)
      2'b00:   extract = {24'h0, shifted[7:0]};
      2'b01:   extract = {16'h0, shifted[15:0]};
      default: extract = d;
    endcase
  endfunction

  assign misaligned = (size == 2'b11) ||
                      (size == 2'b01 && addr_in[0]) ||
                      (size == 2'b10 && addr_in[1:0] != 2'b00);

  // The TIMEOUT-th ACCESS cycle is the last one; an ack there still wins.
  assign last_wait = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = misaligned ? DONE : ACCESS;
      ACCESS:  if (bus.mem_ack || last_wait) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wr_q        <= 1'b0;
      size_q      <= 2'b00;
      wdata_q     <= '0;
      cnt         <= '0;
      rdata       <= '0;
      fault       <= 1'b0;
      inc_address <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          inc_address <= addr_in + 32'd4;
          fault       <= misaligned;
          cnt         <= '0;
          if (!misaligned) begin
            addr_q  <= addr_in;
            wr_q    <= wr;
            size_q  <= size;
            wdata_q <= wdata;
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            if (!wr_q) rdata <= extract(size_q, addr_q[1:0], bus.mem_rdata);
          end else begin
            cnt <= cnt + 1'b1;
            if (last_wait) fault <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state == ACCESS);
  assign done          = (state == DONE);
  assign bus.mem_req   = busy;
  assign bus.mem_we    = busy & wr_q;
  assign bus.mem_be    = busy ? lane_enables(size_q, addr_q[1:0]) : 4'b0000;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = replicate(size_q, wdata_q);

endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface: aligned accesses, lane handling,
// misalignment, timeout edge cases, address wrap and mid-access reset.
module tb_memory_interface;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr_in = '0;
  logic        start = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, fault;
  logic [31:0] inc_address;
  int          checks = 0;
  int          errors = 0;
  int          n;

  memory_interface_if bus_if ();

  memory_interface #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .start(start), .wr(wr),
    .size(size), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .fault(fault), .inc_address(inc_address), .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] s,
                       input logic [31:0] d);
    addr_in = a; wr = w; size = s; wdata = d; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    bus_if.mem_ack = 1'b0;
    bus_if.mem_rdata = '0;
    tick();
    check("rst_req", bus_if.mem_req, 0);
    check("rst_be", bus_if.mem_be, 0);
    check("rst_addr", bus_if.mem_addr, 0);
    check("rst_wdata", bus_if.mem_wdata, 0);
    check("rst_flags", {busy, done, fault}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_inc", inc_address, 0);
    rst_n = 1'b1;
    tick();

    // word read, ack on second ACCESS cycle
    issue(32'h100, 1'b0, 2'b10, 32'h0);
    check("wr_busy", busy, 1);
    check("wr_req_we", {bus_if.mem_req, bus_if.mem_we}, 2'b10);
    check("wr_be", bus_if.mem_be, 4'b1111);
    check("wr_addr", bus_if.mem_addr, 32'h100);
    check("wr_inc", inc_address, 32'h104);
    tick();
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hDEADBEEF;
    tick();
    bus_if.mem_ack = 1'b0;
    check("wr_done", {done, busy, fault, bus_if.mem_req}, 4'b1000);
    check("wr_rdata", rdata, 32'hDEADBEEF);
    tick();
    check("wr_done_clr", done, 0);

    // byte write to lane 3
    issue(32'h203, 1'b1, 2'b00, 32'h0000005A);
    check("bw_addr", bus_if.mem_addr, 32'h200);
    check("bw_be", bus_if.mem_be, 4'b1000);
    check("bw_wdata", bus_if.mem_wdata, 32'h5A5A5A5A);
    check("bw_we", bus_if.mem_we, 1);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check("bw_done", {done, fault}, 2'b10);
    check("bw_rdata_kept", rdata, 32'hDEADBEEF);
    check("bw_be_idle", bus_if.mem_be, 0);
    tick();

    // halfword read from upper half
    issue(32'h12, 1'b0, 2'b01, 32'h0);
    check("hr_be", bus_if.mem_be, 4'b1100);
    check("hr_addr", bus_if.mem_addr, 32'h10);
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hAABBCCDD;
    tick();
    bus_if.mem_ack = 1'b0;
    check("hr_rdata", rdata, 32'h0000AABB);
    check("hr_done", done, 1);
    tick();

    // misaligned word: straight to DONE with fault
    issue(32'h102, 1'b0, 2'b10, 32'h0);
    check("mis_req", bus_if.mem_req, 0);
    check("mis_done", {done, fault}, 2'b11);
    check("mis_inc", inc_address, 32'h106);
    tick();
    check("mis_fault_hold", {done, fault}, 2'b01);

    // reserved size
    issue(32'h0, 1'b0, 2'b11, 32'h0);
    check("rsv_done", {done, fault, bus_if.mem_req}, 3'b110);
    tick();

    // timeout, with a start during busy that must be ignored
    issue(32'h40, 1'b0, 2'b10, 32'h0);
    check("to_fault_clr", fault, 0);
    n = 0;
    while (!done && n < 40) begin
      if (n == 3) begin addr_in = 32'h80; start = 1'b1; end
      else start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    check("to_cycles", n, TIMEOUT);
    check("to_fault", fault, 1);
    check("to_rdata_kept", rdata, 32'h0000AABB);
    check("to_addr_kept", bus_if.mem_addr, 32'h40);
    check("to_inc", inc_address, 32'h44);
    tick();
    tick();
    check("to_no_queue", {busy, done}, 2'b00);

    // ack arriving on the last allowed cycle succeeds
    issue(32'h4, 1'b0, 2'b10, 32'h0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("edge_busy", busy, 1);
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'h12345678;
    tick();
    bus_if.mem_ack = 1'b0;
    check("edge_done", {done, fault}, 2'b10);
    check("edge_rdata", rdata, 32'h12345678);
    tick();

    // ack in IDLE is ignored
    bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hFFFFFFFF;
    tick();
    bus_if.mem_ack = 1'b0;
    check("idle_ack", {busy, done}, 2'b00);
    check("idle_ack_rdata", rdata, 32'h12345678);

    // address wrap then asynchronous reset mid-access
    issue(32'hFFFFFFFC, 1'b0, 2'b10, 32'h0);
    check("wrap_inc", inc_address, 32'h0);
    check("wrap_req", bus_if.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", bus_if.mem_req, 0);
    check("arst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) n++;
      tick();
    end
    check("arst_no_done", n, 0);
    check("arst_regs", {rdata, inc_address}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
